cpu_mem_access_sequencer: RTL and testbench

//  Downstream stage of the CPU-interface control FSM. Watches read_busy/write_busy
//  and runs one memory-bus transaction per access: address setup, request/ack

---
 rtl/cpu_if_pkg.sv | 20 ++
 rtl/cpu_access_timer.sv | 39 +++
 rtl/cpu_mem_access_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cpu_mem_access_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_if_pkg.sv
// rtl/cpu_if_pkg.sv - shared types and widths for the CPU-interface control path
package cpu_if_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } seq_state_e;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 32;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int timer_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_access_timer.sv
// rtl/cpu_access_timer.sv - loadable saturating up/down counter with expiry flag
module cpu_access_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  input  logic             count_up,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count;

  // Saturates at both ends so a long stall can never wrap back into range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en) begin
      if (count_up) begin
        if (count != COUNT_MAX) count <= count + 1'b1;
      end else begin
        if (count != '0) count <= count - 1'b1;
      end
    end
  end

  assign expired = count_up ? (count >= limit) : (count == '0);

endmodule

// File: rtl/cpu_mem_access_sequencer.sv
// rtl/cpu_mem_access_sequencer.sv - memory-bus transaction sequencer behind the CPU control FSM
module cpu_mem_access_sequencer
  import cpu_if_pkg::*;
#(
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int DATA_W       = CPU_DATA_W,
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_busy,
  input  logic              write_busy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              access_complete,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SETUP_W = timer_width(SETUP_CYCLES);
  localparam int WAIT_W  = timer_width(TIMEOUT);
  localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  seq_state_e state_q, state_d;

  logic busy;
  logic start;
  logic setup_load;
  logic wait_clear;
  logic setup_done;
  logic wait_done;
  logic ack_hit;
  logic timeout_hit;

  assign busy = read_busy | write_busy;

  cpu_access_timer #(.WIDTH(SETUP_W)) u_setup_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (1'b0),
    .load       (setup_load),
    .load_value (SETUP_LOAD),
    .count_en   (state_q == SETUP),
    .count_up   (1'b0),
    .limit      ('0),
    .expired    (setup_done)
  );

  cpu_access_timer #(.WIDTH(WAIT_W)) u_wait_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (wait_clear),
    .load       (1'b0),
    .load_value ('0),
    .count_en   (state_q == REQ),
    .count_up   (1'b1),
    .limit      (WAIT_LIMIT),
    .expired    (wait_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Dropping both busy lines mid-access is an abort and outranks ack/timeout.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    setup_load  = 1'b0;
    wait_clear  = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (busy) begin
          start = 1'b1;
          if (SETUP_CYCLES == 0) begin
            state_d    = REQ;
            wait_clear = 1'b1;
          end else begin
            state_d    = SETUP;
            setup_load = 1'b1;
          end
        end
      end
      SETUP: begin
        if (!busy) begin
          state_d = IDLE;
        end else if (setup_done) begin
          state_d    = REQ;
          wait_clear = 1'b1;
        end
      end
      REQ: begin
        if (!busy) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          state_d = DONE;
          ack_hit = 1'b1;
        end else if (wait_done) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!busy) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req         <= 1'b0;
      access_complete <= 1'b0;
      rdata_valid     <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      mem_req         <= (state_d == REQ);
      access_complete <= (state_d == DONE);
      rdata_valid     <= ack_hit & ~mem_we;
      if (start)            timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Bus-side address/data are frozen at access start so the CPU side may move on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_we    <= write_busy;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (ack_hit && !mem_we) begin
      rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_access_sequencer.sv
// tb/tb_cpu_mem_access_sequencer.sv - randomized transaction-level check of cpu_mem_access_sequencer
module tb_cpu_mem_access_sequencer;

  localparam int SETUP_A   = 1;
  localparam int TIMEOUT_A = 4;
  localparam int SETUP_B   = 0;
  localparam int TIMEOUT_B = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_busy;
  logic        write_busy;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;

  logic        access_complete [2];
  logic        rdata_valid     [2];
  logic        timeout_err     [2];
  logic        mem_req         [2];
  logic        mem_we          [2];
  logic        mem_ack         [2];
  logic [31:0] rdata           [2];
  logic [31:0] mem_wdata       [2];
  logic [31:0] mem_rdata       [2];
  logic [15:0] mem_addr        [2];

  int          setup_c   [2] = '{SETUP_A, SETUP_B};
  int          timeout_c [2] = '{TIMEOUT_A, TIMEOUT_B};
  logic [31:0] model_rdata [2];
  logic        te_exp      [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_mem_access_sequencer #(
    .ADDR_W(16), .DATA_W(32), .SETUP_CYCLES(SETUP_A), .TIMEOUT(TIMEOUT_A)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .read_busy(read_busy), .write_busy(write_busy),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .access_complete(access_complete[0]),
    .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .timeout_err(timeout_err[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0])
  );

  cpu_mem_access_sequencer #(
    .ADDR_W(16), .DATA_W(32), .SETUP_CYCLES(SETUP_B), .TIMEOUT(TIMEOUT_B)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .read_busy(read_busy), .write_busy(write_busy),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .access_complete(access_complete[1]),
    .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .timeout_err(timeout_err[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_u%0d_ctrl", tag, i),
               {access_complete[i], rdata_valid[i], timeout_err[i], mem_req[i], mem_we[i]}, '0);
      check_eq($sformatf("%s_u%0d_addr", tag, i), mem_addr[i], '0);
      check_eq($sformatf("%s_u%0d_wdata", tag, i), mem_wdata[i], '0);
      check_eq($sformatf("%s_u%0d_rdata", tag, i), rdata[i], '0);
    end
  endtask

  // One CPU access, d = REQ-cycle index of the ack (-1: never), abort_at = u_a REQ
  // index at which busy is dropped (-1: never), hold = busy cycles kept after both complete.
  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input int d, input logic [31:0] ack_data,
                         input int abort_at, input int hold);
    int   req_cnt [2];
    bit   done    [2];
    bit   aborted [2];
    bit   prev_req[2];
    int   exp_req [2];
    bit   exp_to  [2];
    bit   dropped;
    bit   finished;
    int   hold_left;
    int   post;
    for (int i = 0; i < 2; i++) begin
      exp_to[i]   = !(d >= 0 && d < timeout_c[i]);
      exp_req[i]  = exp_to[i] ? timeout_c[i] : d + 1;
      req_cnt[i]  = 0;
      done[i]     = 1'b0;
      aborted[i]  = 1'b0;
      prev_req[i] = 1'b0;
    end
    dropped   = 1'b0;
    finished  = 1'b0;
    hold_left = hold;
    post      = 0;
    read_busy  = rd;
    write_busy = wr;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    for (int t = 1; t <= 80 && !finished; t++) begin
      @(negedge clk);
      if (t == 1) begin
        te_exp[0] = 1'b0;
        te_exp[1] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (mem_req[i] && req_cnt[i] == 0 && !done[i] && !aborted[i])
          check_eq($sformatf("u%0d_req_latency", i), t, setup_c[i] + 1);
        if (done[i] || aborted[i])
          check_eq($sformatf("u%0d_no_req_after_end", i), mem_req[i], 1'b0);
        if (mem_req[i]) req_cnt[i]++;
        if (!dropped) begin
          check_eq($sformatf("u%0d_mem_we", i), mem_we[i], wr);
          check_eq($sformatf("u%0d_mem_addr", i), mem_addr[i], addr);
          check_eq($sformatf("u%0d_mem_wdata", i), mem_wdata[i], wdata);
        end
        if (access_complete[i]) begin
          check_eq($sformatf("u%0d_single_complete", i), {done[i], aborted[i]}, 2'b00);
          check_eq($sformatf("u%0d_req_cycles", i), req_cnt[i], exp_req[i]);
          check_eq($sformatf("u%0d_complete_timing", i), {prev_req[i], mem_req[i]}, 2'b10);
          check_eq($sformatf("u%0d_rdata_valid", i), rdata_valid[i], !wr && !exp_to[i]);
          if (!wr && !exp_to[i]) model_rdata[i] = ack_data;
          te_exp[i] = exp_to[i];
          done[i]   = 1'b1;
        end else begin
          check_eq($sformatf("u%0d_rdata_valid_idle", i), rdata_valid[i], 1'b0);
        end
        check_eq($sformatf("u%0d_rdata", i), rdata[i], model_rdata[i]);
        check_eq($sformatf("u%0d_timeout_err", i), timeout_err[i], te_exp[i]);
        prev_req[i] = mem_req[i];
        if (mem_req[i] && d >= 0 && req_cnt[i] == d + 1) begin
          mem_ack[i]   = 1'b1;
          mem_rdata[i] = ack_data;
        end else begin
          mem_ack[i]   = mem_req[i] ? 1'b0 : 1'($urandom_range(0, 1));
          mem_rdata[i] = $urandom;
        end
      end
      if (t == 1) begin
        cpu_addr  = 16'($urandom);
        cpu_wdata = $urandom;
      end
      if (dropped) begin
        post++;
        if (post == 2) finished = 1'b1;
      end else if (abort_at >= 0 && !done[0] && req_cnt[0] == abort_at + 1) begin
        dropped = 1'b1;
        for (int i = 0; i < 2; i++) if (!done[i]) aborted[i] = 1'b1;
      end else if (done[0] && done[1]) begin
        if (hold_left == 0) dropped = 1'b1;
        else hold_left--;
      end
      if (dropped) begin
        read_busy  = 1'b0;
        write_busy = 1'b0;
      end
    end
    check_eq("txn_within_budget", finished, 1'b1);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("u%0d_txn_ended", i), done[i] | aborted[i], 1'b1);
    mem_ack[0] = 1'b0;
    mem_ack[1] = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    read_busy  = 1'b0;
    write_busy = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    for (int i = 0; i < 2; i++) begin
      mem_ack[i]     = 1'b0;
      mem_rdata[i]   = '0;
      model_rdata[i] = '0;
      te_exp[i]      = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 16'h1234, 32'h0BAD_F00D, 2, 32'hDEAD_BEEF, -1, 0);
    check_eq("read_deadbeef", rdata[0], 32'hDEAD_BEEF);
    run_txn(1'b0, 1'b1, 16'h0040, 32'h1234_5678, 0, 32'h5555_AAAA, -1, 0);
    run_txn(1'b1, 1'b0, 16'h0100, 32'h0, -1, 32'h7777_7777, -1, 0);
    run_txn(1'b1, 1'b0, 16'h0200, 32'h0, 1, 32'hCAFE_0001, -1, 2);
    run_txn(1'b1, 1'b1, 16'h0300, 32'hA5A5_5A5A, 1, 32'h1111_2222, -1, 0);
    run_txn(1'b0, 1'b1, 16'h0400, 32'h0F0F_F0F0, 3, 32'h3333_4444, 1, 0);

    for (int n = 0; n < 40; n++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      run_txn(rd, wr, 16'($urandom), $urandom, int'($urandom_range(0, 6)) - 1, $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
              int'($urandom_range(0, 2)));
    end

    read_busy = 1'b1;
    cpu_addr  = 16'hBEEF;
    cpu_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_req_a", mem_req[0], 1'b1);
    #3 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    read_busy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    te_exp[0]      = 1'b0;
    te_exp[1]      = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");
    run_txn(1'b1, 1'b0, 16'h0055, 32'h0, 0, 32'h8765_4321, -1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
